// File: rtl/cordic_vec_seq.sv
// Iterative CORDIC vectoring engine: one shared micro-rotation stage stepped ITER times.
// Optional quadrant pre-rotation on load is enabled with `define CORDIC_QUAD_EN.
module cordic_vec_seq #(
    parameter int ITER = 12,
    parameter int IW   = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] Xin,
    input  logic [15:0] Yin,
    input  logic [15:0] angle,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Xout,
    output logic [15:0] Yout,
    output logic [15:0] Zout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic signed [IW-1:0] SAT_MAX = IW'(32767);
    localparam logic signed [IW-1:0] SAT_MIN = -IW'(32768);
    localparam logic [15:0]          HALF_PI = 16'd25736;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic signed [IW-1:0] r_x;
    logic signed [IW-1:0] r_y;
    logic [15:0]          r_z;

    logic signed [IW-1:0] w_xin;
    logic signed [IW-1:0] w_yin;
    logic signed [IW-1:0] w_ld_x;
    logic signed [IW-1:0] w_ld_y;
    logic [15:0]          w_ld_z;

    logic signed [IW-1:0] w_xs;
    logic signed [IW-1:0] w_ys;
    logic signed [IW-1:0] w_rot_x;
    logic signed [IW-1:0] w_rot_y;
    logic [15:0]          w_rot_z;
    logic [15:0]          w_atan;
    logic                 w_yneg;
    logic                 w_last;

    function automatic logic [15:0] atan_rom(input logic [3:0] idx);
        logic [15:0] v;
        v = 16'd0;
        unique case (idx)
            4'd0:    v = 16'd12868;
            4'd1:    v = 16'd7597;
            4'd2:    v = 16'd4014;
            4'd3:    v = 16'd2038;
            4'd4:    v = 16'd1023;
            4'd5:    v = 16'd512;
            4'd6:    v = 16'd256;
            4'd7:    v = 16'd128;
            4'd8:    v = 16'd64;
            4'd9:    v = 16'd32;
            4'd10:   v = 16'd16;
            4'd11:   v = 16'd8;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] sat16(input logic signed [IW-1:0] v);
        logic [15:0] r;
        if (v > SAT_MAX) begin
            r = 16'h7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    assign w_xin = {{(IW-16){Xin[15]}}, Xin};
    assign w_yin = {{(IW-16){Yin[15]}}, Yin};

`ifdef CORDIC_QUAD_EN
    // Left half-plane: rotate by +/-90 deg so the iterations stay in range.
    always_comb begin
        w_ld_x = w_xin;
        w_ld_y = w_yin;
        w_ld_z = angle;
        if (Xin[15]) begin
            if (!Yin[15]) begin
                w_ld_x = w_yin;
                w_ld_y = -w_xin;
                w_ld_z = angle + HALF_PI;
            end else begin
                w_ld_x = -w_yin;
                w_ld_y = w_xin;
                w_ld_z = angle - HALF_PI;
            end
        end
    end
`else
    always_comb begin
        w_ld_x = w_xin;
        w_ld_y = w_yin;
        w_ld_z = angle;
        if (HALF_PI == 16'd0) begin
            w_ld_z = angle;
        end
    end
`endif

    assign w_xs   = r_x >>> r_cnt;
    assign w_ys   = r_y >>> r_cnt;
    assign w_yneg = r_y[IW-1];
    assign w_atan = atan_rom(r_cnt);
    assign w_last = (r_cnt == 4'(ITER - 1));

    always_comb begin
        if (w_yneg) begin
            w_rot_x = r_x - w_ys;
            w_rot_y = r_y + w_xs;
            w_rot_z = r_z - w_atan;
        end else begin
            w_rot_x = r_x + w_ys;
            w_rot_y = r_y - w_xs;
            w_rot_z = r_z + w_atan;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= 16'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= 4'd0;
                        r_x   <= w_ld_x;
                        r_y   <= w_ld_y;
                        r_z   <= w_ld_z;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 4'd1;
                    r_x   <= w_rot_x;
                    r_y   <= w_rot_y;
                    r_z   <= w_rot_z;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign Xout = sat16(r_x);
    assign Yout = sat16(r_y);
    assign Zout = r_z;

endmodule

// File: tb/tb_cordic_vec_seq.sv
// Directed self-checking bench for cordic_vec_seq (ITER=12).
module tb_cordic_vec_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Xin;
    logic [15:0] Yin;
    logic [15:0] angle;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Xout;
    logic [15:0] Yout;
    logic [15:0] Zout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    cordic_vec_seq #(.ITER(12), .IW(18)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Xin      (Xin),
        .Yin      (Yin),
        .angle    (angle),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Xout     (Xout),
        .Yout     (Yout),
        .Zout     (Zout),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic int sdiff(input logic [15:0] a, input logic [15:0] b);
        logic signed [15:0] d;
        d = a - b;
        return int'(d);
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] a, output int lat,
                          output logic [15:0] xo, output logic [15:0] zo);
        int n;
        n = 0;
        Xin      = x;
        Yin      = y;
        angle    = a;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        xo = Xout;
        zo = Zout;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Xin       = 16'd0;
        Yin       = 16'd0;
        angle     = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (Xout !== 16'd0 || Yout !== 16'd0 || Zout !== 16'd0) begin
            failures++;
            $display("FAIL reset_data got %h %h %h want 0 0 0", Xout, Yout, Zout);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] xo, zo;
        out_ready = 1'b1;
        Xin = 16'd16384; Yin = 16'd0; angle = 16'd0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_flags got busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        xo = Xout;
        zo = Zout;
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL basic_latency got %0d want 12", lat);
        end
        checks++;
        if (sdiff(zo, 16'd0) > 16 || sdiff(zo, 16'd0) < -16) begin
            failures++;
            $display("FAIL basic_z got %0d want 0+-16", $signed(zo));
        end
        checks++;
        if (sdiff(xo, 16'd26981) > 16 || sdiff(xo, 16'd26981) < -16) begin
            failures++;
            $display("FAIL basic_x got %0d want 26981+-16", $signed(xo));
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_flags got busy=%b rdy=%b want 0 0", busy, in_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ready_return got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vx [4] = '{16'd10000, 16'd0,     16'd10000, 16'd16384};
        logic [15:0] vy [4] = '{16'd10000, 16'd10000, 16'hD8F0,  16'd0};
        logic [15:0] va [4] = '{16'd0,     16'd0,     16'd0,     16'd1000};
        logic [15:0] vz [4] = '{16'd12868, 16'd25736, 16'd52668, 16'd1000};
        int lat;
        logic [15:0] xo, zo;
        for (int i = 0; i < 4; i++) begin
            run_op(vx[i], vy[i], va[i], lat, xo, zo);
            checks++;
            if (sdiff(zo, vz[i]) > 16 || sdiff(zo, vz[i]) < -16) begin
                failures++;
                $display("FAIL vec%0d_z got %0d want %0d+-16", i, zo, vz[i]);
            end
            if (i == 0) begin
                checks++;
                if (sdiff(xo, 16'd23290) > 16 || sdiff(xo, 16'd23290) < -16) begin
                    failures++;
                    $display("FAIL vec0_x got %0d want 23290+-16", xo);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [15:0] xo, zo;
        run_op(16'd32767, 16'd32767, 16'd0, lat, xo, zo);
        checks++;
        if (xo !== 16'd32767) begin
            failures++;
            $display("FAIL sat_x got %0d want 32767", xo);
        end
        checks++;
        if (sdiff(zo, 16'd12868) > 16 || sdiff(zo, 16'd12868) < -16) begin
            failures++;
            $display("FAIL sat_z got %0d want 12868+-16", zo);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_handshake();
        int lat;
        logic [15:0] hx, hy, hz;
        out_ready = 1'b0;
        Xin = 16'd10000; Yin = 16'd10000; angle = 16'd0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        Xin = 16'd16384; Yin = 16'd0; angle = 16'd0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 4;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL hs_latency got %0d want 12", lat);
        end
        hx = Xout; hy = Yout; hz = Zout;
        checks++;
        if (sdiff(hz, 16'd12868) > 16 || sdiff(hz, 16'd12868) < -16) begin
            failures++;
            $display("FAIL hs_first_z got %0d want 12868+-16", hz);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                Xout !== hx || Yout !== hy || Zout !== hz) begin
                failures++;
                $display("FAIL hs_hold%0d got vld=%b rdy=%b %h %h %h want 1 0 %h %h %h",
                         c, out_valid, in_ready, Xout, Yout, Zout, hx, hy, hz);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_no_restart got busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        int lat;
        logic [15:0] xo, zo;
        out_ready = 1'b1;
        Xin = 16'd10000; Yin = 16'd10000; angle = 16'd0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            Xout !== 16'd0 || Yout !== 16'd0 || Zout !== 16'd0) begin
            failures++;
            $display("FAIL abort_state got vld=%b busy=%b rdy=%b %h %h %h want 0 0 1 0 0 0",
                     out_valid, busy, in_ready, Xout, Yout, Zout);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        repeat (16) begin
            @(posedge clock); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_valid got %0d valid cycles want 0", seen);
        end
        run_op(16'd16384, 16'd0, 16'd0, lat, xo, zo);
        checks++;
        if (lat !== 12 || sdiff(xo, 16'd26981) > 16 || sdiff(xo, 16'd26981) < -16) begin
            failures++;
            $display("FAIL abort_fresh got lat=%0d x=%0d want 12 26981+-16", lat, xo);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_quadrant();
        int lat;
        logic [15:0] xo, zo;
        run_op(16'hD8F0, 16'd10000, 16'd0, lat, xo, zo);
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL quad_latency got %0d want 12", lat);
        end
`ifdef CORDIC_QUAD_EN
        checks++;
        if (sdiff(zo, 16'd38604) > 16 || sdiff(zo, 16'd38604) < -16) begin
            failures++;
            $display("FAIL quad2_z got %0d want 38604+-16", zo);
        end
`endif
        @(posedge clock); #1;
        run_op(16'hD8F0, 16'hD8F0, 16'd0, lat, xo, zo);
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL quad3_latency got %0d want 12", lat);
        end
`ifdef CORDIC_QUAD_EN
        checks++;
        if (sdiff(zo, 16'd26932) > 16 || sdiff(zo, 16'd26932) < -16) begin
            failures++;
            $display("FAIL quad3_z got %0d want 26932+-16", zo);
        end
`endif
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_saturation();
        test_handshake();
        test_reset_abort();
        test_quadrant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
